// File: rtl/axi_stream_insert_header_arb.sv
// -----------------------------------------------------------------------------
// axi_stream_insert_header_arb
//
// Packet-level round-robin arbiter that shares one header inserter between
// NUM_CH requesters. A channel is granted per packet: its header is forwarded
// to the inserter's insert port, then its data beats are forwarded to the
// inserter's data port until the last beat is accepted. The data path has no
// storage; valid/data/ready are muxed combinationally from the granted slice.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   ch_en               : per-channel arbitration enable (used only in IDLE)
//   s_*_insert          : per-channel header ports (packed, channel i = slice i)
//   s_*_in              : per-channel AXI-Stream data ports (packed)
//   m_*_insert          : header port toward the inserter
//   m_*_in              : data port toward the inserter
//   grant_ch            : registered index of the current/most recent grant
//   busy                : registered, high while a packet owns the inserter
//   pkt_done            : registered one-cycle pulse after the last handshake
// -----------------------------------------------------------------------------
module axi_stream_insert_header_arb #(
  parameter int NUM_CH       = 4,
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int CH_WD        = $clog2(NUM_CH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CH-1:0]                ch_en,
  input  logic [NUM_CH-1:0]                s_valid_insert,
  input  logic [NUM_CH*DATA_WD-1:0]        s_data_insert,
  input  logic [NUM_CH*DATA_BYTE_WD-1:0]   s_keep_insert,
  input  logic [NUM_CH*BYTE_CNT_WD-1:0]    s_byte_insert_cnt,
  output logic [NUM_CH-1:0]                s_ready_insert,
  input  logic [NUM_CH-1:0]                s_valid_in,
  input  logic [NUM_CH*DATA_WD-1:0]        s_data_in,
  input  logic [NUM_CH*DATA_BYTE_WD-1:0]   s_keep_in,
  input  logic [NUM_CH-1:0]                s_last_in,
  output logic [NUM_CH-1:0]                s_ready_in,
  output logic                             m_valid_insert,
  output logic [DATA_WD-1:0]               m_data_insert,
  output logic [DATA_BYTE_WD-1:0]          m_keep_insert,
  output logic [BYTE_CNT_WD-1:0]           m_byte_insert_cnt,
  input  logic                             m_ready_insert,
  output logic                             m_valid_in,
  output logic [DATA_WD-1:0]               m_data_in,
  output logic [DATA_BYTE_WD-1:0]          m_keep_in,
  output logic                             m_last_in,
  input  logic                             m_ready_in,
  output logic [CH_WD-1:0]                 grant_ch,
  output logic                             busy,
  output logic                             pkt_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CH_WD-1:0]  rr_ptr;
  logic [CH_WD-1:0]  winner;
  logic [CH_WD-1:0]  ptr_after_grant;
  logic [NUM_CH-1:0] req;
  logic              hdr_hs;
  logic              last_hs;

  assign req     = s_valid_insert & ch_en;
  assign hdr_hs  = m_valid_insert & m_ready_insert;
  assign last_hs = m_valid_in & m_ready_in & m_last_in;

  // Pointer advances past the channel that just finished, wrapping at NUM_CH.
  assign ptr_after_grant = (grant_ch == CH_WD'(NUM_CH - 1)) ? {CH_WD{1'b0}}
                                                            : grant_ch + CH_WD'(1);

  // Round-robin pick: scan offsets from high to low so the nearest requester
  // at or above rr_ptr is the last (and therefore winning) assignment.
  always_comb begin
    logic [CH_WD-1:0] idx;
    winner = rr_ptr;
    idx    = rr_ptr;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx    = CH_WD'((int'(rr_ptr) + i) % NUM_CH);
      winner = req[idx] ? idx : winner;
    end
  end

  // Output mux: only the granted slice is connected, and only in its phase.
  always_comb begin
    m_valid_insert    = 1'b0;
    m_data_insert     = {DATA_WD{1'b0}};
    m_keep_insert     = {DATA_BYTE_WD{1'b0}};
    m_byte_insert_cnt = {BYTE_CNT_WD{1'b0}};
    m_valid_in        = 1'b0;
    m_data_in         = {DATA_WD{1'b0}};
    m_keep_in         = {DATA_BYTE_WD{1'b0}};
    m_last_in         = 1'b0;
    s_ready_insert    = {NUM_CH{1'b0}};
    s_ready_in        = {NUM_CH{1'b0}};
    case (state)
      HDR: begin
        m_valid_insert           = s_valid_insert[grant_ch];
        m_data_insert            = s_data_insert[int'(grant_ch)*DATA_WD +: DATA_WD];
        m_keep_insert            = s_keep_insert[int'(grant_ch)*DATA_BYTE_WD +: DATA_BYTE_WD];
        m_byte_insert_cnt        = s_byte_insert_cnt[int'(grant_ch)*BYTE_CNT_WD +: BYTE_CNT_WD];
        s_ready_insert[grant_ch] = m_ready_insert;
      end
      DATA: begin
        m_valid_in           = s_valid_in[grant_ch];
        m_data_in            = s_data_in[int'(grant_ch)*DATA_WD +: DATA_WD];
        m_keep_in            = s_keep_in[int'(grant_ch)*DATA_BYTE_WD +: DATA_BYTE_WD];
        m_last_in            = s_last_in[grant_ch];
        s_ready_in[grant_ch] = m_ready_in;
      end
      default: begin
        m_valid_insert = 1'b0;
        m_valid_in     = 1'b0;
      end
    endcase
  end

  // Next-state logic. A dropped header valid in HDR simply keeps us waiting.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (|req) state_next = HDR;
        else      state_next = IDLE;
      end
      HDR: begin
        if (hdr_hs) state_next = DATA;
        else        state_next = HDR;
      end
      DATA: begin
        if (last_hs) state_next = IDLE;
        else         state_next = DATA;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, grant, pointer and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= {CH_WD{1'b0}};
      grant_ch <= {CH_WD{1'b0}};
      busy     <= 1'b0;
      pkt_done <= 1'b0;
    end else begin
      state    <= state_next;
      busy     <= (state_next == HDR) || (state_next == DATA);
      pkt_done <= (state == DATA) && last_hs;
      if ((state == IDLE) && (|req)) begin
        grant_ch <= winner;
      end
      if ((state == DATA) && last_hs) begin
        rr_ptr <= ptr_after_grant;
      end
    end
  end

endmodule
